shared_tlb_arbiter: RTL and testbench

Sequences the shared second-level TLB of the 64-bit MMU configuration (64-entry shared TLB behind 2-entry instruction and data TLBs). It accepts miss requests from the ITLB and DTLB and arbitrates them round-robin onto the single shared-TLB lookup port. On a shared-TLB miss it launches a page-table walk, refills the shared TLB, and returns the translation to the requester that owns the transaction. One transaction is in flight at a time.

---
 rtl/shared_tlb_arbiter.sv | 147 ++++++++++++++
 tb/tb_shared_tlb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_tlb_arbiter.sv
// rtl/shared_tlb_arbiter.sv - round-robin ITLB/DTLB miss sequencer for the shared second-level TLB
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (address-space flush)
//   itlb_req_i/itlb_vpn_i/itlb_gnt_o/itlb_rsp_valid_o : ITLB miss channel
//   dtlb_req_i/dtlb_vpn_i/dtlb_gnt_o/dtlb_rsp_valid_o : DTLB miss channel
//   rsp_ppn_o/rsp_err_o                               : shared response data, qualified by *_rsp_valid_o
//   stlb_lu_*                                         : shared-TLB lookup port (hit returns next cycle)
//   stlb_fill_*                                       : shared-TLB refill strobe and data
//   ptw_*                                             : page-table walker handshake (level req, pulse done)
module shared_tlb_arbiter #(
    parameter int VPN_W = 27,
    parameter int PPN_W = 44
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             itlb_req_i,
    input  logic [VPN_W-1:0] itlb_vpn_i,
    output logic             itlb_gnt_o,
    output logic             itlb_rsp_valid_o,
    input  logic             dtlb_req_i,
    input  logic [VPN_W-1:0] dtlb_vpn_i,
    output logic             dtlb_gnt_o,
    output logic             dtlb_rsp_valid_o,
    output logic [PPN_W-1:0] rsp_ppn_o,
    output logic             rsp_err_o,
    output logic             stlb_lu_valid_o,
    output logic [VPN_W-1:0] stlb_lu_vpn_o,
    input  logic             stlb_lu_hit_i,
    input  logic [PPN_W-1:0] stlb_lu_ppn_i,
    output logic             stlb_fill_o,
    output logic [VPN_W-1:0] stlb_fill_vpn_o,
    output logic [PPN_W-1:0] stlb_fill_ppn_o,
    output logic             ptw_req_o,
    output logic [VPN_W-1:0] ptw_vpn_o,
    input  logic             ptw_done_i,
    input  logic [PPN_W-1:0] ptw_ppn_i,
    input  logic             ptw_err_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WALK,
        S_RESP
    } state_t;

    state_t             state;
    logic               last_d;     // 1: DTLB was granted last, 0: ITLB was granted last
    logic               owner_d;    // owner of the transaction in flight
    logic               discard;    // walk was flushed; drop its result
    logic [VPN_W-1:0]   vpn_q;
    logic [PPN_W-1:0]   ppn_q;
    logic               err_q;

    logic               can_grant;
    logic               pick_d;
    logic               any_gnt;
    logic               walk_done;

    // DTLB wins unless ITLB is also requesting and DTLB held the last grant.
    assign can_grant  = (state == S_IDLE) && !flush_i;
    assign pick_d     = dtlb_req_i && (!itlb_req_i || !last_d);
    assign dtlb_gnt_o = can_grant && pick_d;
    assign itlb_gnt_o = can_grant && itlb_req_i && !pick_d;
    assign any_gnt    = dtlb_gnt_o || itlb_gnt_o;

    assign walk_done  = (state == S_WALK) && ptw_done_i;

    // The refill must coincide with the walker's done pulse, so it is decoded
    // combinationally; a flush in that same cycle also blocks the stale fill.
    assign stlb_fill_o     = walk_done && !ptw_err_i && !discard && !flush_i;
    assign stlb_fill_vpn_o = vpn_q;
    assign stlb_fill_ppn_o = stlb_fill_o ? ptw_ppn_i : '0;

    assign stlb_lu_valid_o  = (state == S_LOOKUP);
    assign stlb_lu_vpn_o    = vpn_q;
    assign ptw_req_o        = (state == S_WALK);
    assign ptw_vpn_o        = vpn_q;

    assign itlb_rsp_valid_o = (state == S_RESP) && !flush_i && !owner_d;
    assign dtlb_rsp_valid_o = (state == S_RESP) && !flush_i && owner_d;
    assign rsp_ppn_o        = ppn_q;
    assign rsp_err_o        = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            last_d  <= 1'b0;
            owner_d <= 1'b0;
            discard <= 1'b0;
            vpn_q   <= '0;
            ppn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    discard <= 1'b0;
                    if (any_gnt) begin
                        vpn_q   <= pick_d ? dtlb_vpn_i : itlb_vpn_i;
                        owner_d <= pick_d;
                        last_d  <= pick_d;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state <= flush_i ? S_IDLE : S_CHECK;
                end
                S_CHECK: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else if (stlb_lu_hit_i) begin
                        ppn_q <= stlb_lu_ppn_i;
                        err_q <= 1'b0;
                        state <= S_RESP;
                    end else begin
                        state <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (ptw_done_i) begin
                        if (discard || flush_i) begin
                            discard <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            ppn_q <= ptw_ppn_i;
                            err_q <= ptw_err_i;
                            state <= S_RESP;
                        end
                    end else if (flush_i) begin
                        // The walker cannot be cancelled; keep the request up and drop the result.
                        discard <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_tlb_arbiter.sv
// tb/tb_shared_tlb_arbiter.sv - randomized bench for shared_tlb_arbiter with transaction-timing reference model
module tb_shared_tlb_arbiter;

    localparam int VPN_W = 27;
    localparam int PPN_W = 44;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             itlb_req_i;
    logic [VPN_W-1:0] itlb_vpn_i;
    logic             itlb_gnt_o;
    logic             itlb_rsp_valid_o;
    logic             dtlb_req_i;
    logic [VPN_W-1:0] dtlb_vpn_i;
    logic             dtlb_gnt_o;
    logic             dtlb_rsp_valid_o;
    logic [PPN_W-1:0] rsp_ppn_o;
    logic             rsp_err_o;
    logic             stlb_lu_valid_o;
    logic [VPN_W-1:0] stlb_lu_vpn_o;
    logic             stlb_lu_hit_i;
    logic [PPN_W-1:0] stlb_lu_ppn_i;
    logic             stlb_fill_o;
    logic [VPN_W-1:0] stlb_fill_vpn_o;
    logic [PPN_W-1:0] stlb_fill_ppn_o;
    logic             ptw_req_o;
    logic [VPN_W-1:0] ptw_vpn_o;
    logic             ptw_done_i;
    logic [PPN_W-1:0] ptw_ppn_i;
    logic             ptw_err_i;

    shared_tlb_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .itlb_req_i(itlb_req_i), .itlb_vpn_i(itlb_vpn_i), .itlb_gnt_o(itlb_gnt_o),
        .itlb_rsp_valid_o(itlb_rsp_valid_o),
        .dtlb_req_i(dtlb_req_i), .dtlb_vpn_i(dtlb_vpn_i), .dtlb_gnt_o(dtlb_gnt_o),
        .dtlb_rsp_valid_o(dtlb_rsp_valid_o),
        .rsp_ppn_o(rsp_ppn_o), .rsp_err_o(rsp_err_o),
        .stlb_lu_valid_o(stlb_lu_valid_o), .stlb_lu_vpn_o(stlb_lu_vpn_o),
        .stlb_lu_hit_i(stlb_lu_hit_i), .stlb_lu_ppn_i(stlb_lu_ppn_i),
        .stlb_fill_o(stlb_fill_o), .stlb_fill_vpn_o(stlb_fill_vpn_o), .stlb_fill_ppn_o(stlb_fill_ppn_o),
        .ptw_req_o(ptw_req_o), .ptw_vpn_o(ptw_vpn_o), .ptw_done_i(ptw_done_i),
        .ptw_ppn_i(ptw_ppn_i), .ptw_err_i(ptw_err_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester agents
    bit               ireq, dreq;
    logic [VPN_W-1:0] ivpn, dvpn;
    bit               rnd = 1'b0;
    bit               hold_both = 1'b0;
    int               flush_at = -1;
    bit               flush_now;

    // Plan override for directed transactions
    bit               fp_en = 1'b0;
    bit               fp_hit;
    logic [PPN_W-1:0] fp_ppn;
    bit               fp_err;
    int               fp_lat;

    // Reference model: one transaction described by its grant cycle and planned timing
    int               cyc;
    bit               busy;
    bit               own_d;
    logic [VPN_W-1:0] t_vpn;
    bit               t_hit;
    logic [PPN_W-1:0] t_ppn;
    bit               t_err;
    int               t0, td;
    bit               disc;
    bit               last_m;
    bit               gnt_log[$];

    function automatic int resp_cycle();
        return t_hit ? t0 + 3 : td + 1;
    endfunction

    task automatic drive();
        if (rnd) begin
            if (!ireq && $urandom_range(3) == 0) begin ireq = 1'b1; ivpn = VPN_W'($urandom); end
            else if (ireq && $urandom_range(39) == 0) ireq = 1'b0;
            if (!dreq && $urandom_range(3) == 0) begin dreq = 1'b1; dvpn = VPN_W'($urandom); end
            else if (dreq && $urandom_range(39) == 0) dreq = 1'b0;
            flush_now = ($urandom_range(29) == 0);
        end else begin
            if (hold_both) begin ireq = 1'b1; dreq = 1'b1; end
            flush_now = (cyc == flush_at);
        end
        itlb_req_i = ireq; itlb_vpn_i = ivpn;
        dtlb_req_i = dreq; dtlb_vpn_i = dvpn;
        flush_i    = flush_now;
        if (busy && cyc == t0 + 2) begin
            stlb_lu_hit_i = t_hit;
            stlb_lu_ppn_i = t_ppn;
        end else begin
            stlb_lu_hit_i = 1'($urandom);
            stlb_lu_ppn_i = PPN_W'({$urandom, $urandom});
        end
        if (busy && !t_hit && cyc == td) begin
            ptw_done_i = 1'b1;
            ptw_ppn_i  = t_ppn;
            ptw_err_i  = t_err;
        end else begin
            ptw_done_i = 1'b0;
            ptw_ppn_i  = PPN_W'({$urandom, $urandom});
            ptw_err_i  = 1'($urandom);
        end
    endtask

    task automatic check_and_update();
        bit e_ig, e_dg, e_lu, e_ptw, e_fill, e_irsp, e_drsp, pick_d, walking;
        e_ig = 0; e_dg = 0; e_lu = 0; e_ptw = 0; e_fill = 0; e_irsp = 0; e_drsp = 0;
        pick_d  = dreq && (!ireq || !last_m);
        walking = busy && !t_hit && cyc >= t0 + 3 && cyc <= td;
        if (!busy) begin
            if (!flush_now && (ireq || dreq)) begin
                e_dg = pick_d;
                e_ig = !pick_d;
            end
        end else begin
            e_lu   = (cyc == t0 + 1);
            e_ptw  = walking;
            e_fill = walking && cyc == td && !t_err && !disc && !flush_now;
            if (cyc == resp_cycle() && !flush_now) begin
                e_drsp = own_d;
                e_irsp = !own_d;
            end
        end
        chk("itlb_gnt", itlb_gnt_o, e_ig);
        chk("dtlb_gnt", dtlb_gnt_o, e_dg);
        chk("lu_valid", stlb_lu_valid_o, e_lu);
        chk("ptw_req", ptw_req_o, e_ptw);
        chk("fill", stlb_fill_o, e_fill);
        chk("itlb_rsp", itlb_rsp_valid_o, e_irsp);
        chk("dtlb_rsp", dtlb_rsp_valid_o, e_drsp);
        if (e_lu)  chk("lu_vpn", stlb_lu_vpn_o, t_vpn);
        if (e_ptw) chk("ptw_vpn", ptw_vpn_o, t_vpn);
        if (e_fill) begin
            chk("fill_vpn", stlb_fill_vpn_o, t_vpn);
            chk("fill_ppn", stlb_fill_ppn_o, t_ppn);
        end
        if (e_irsp || e_drsp) begin
            chk("rsp_ppn", rsp_ppn_o, t_ppn);
            chk("rsp_err", rsp_err_o, t_hit ? 1'b0 : t_err);
        end

        if (!busy) begin
            if (e_ig || e_dg) begin
                busy   = 1'b1;
                t0     = cyc;
                own_d  = e_dg;
                last_m = e_dg;
                t_vpn  = e_dg ? dvpn : ivpn;
                disc   = 1'b0;
                gnt_log.push_back(e_dg);
                if (e_dg) dreq = 1'b0; else ireq = 1'b0;
                if (fp_en) begin
                    t_hit = fp_hit; t_ppn = fp_ppn; t_err = fp_err; td = t0 + 3 + fp_lat;
                end else begin
                    t_hit = 1'($urandom);
                    t_ppn = PPN_W'({$urandom, $urandom});
                    t_err = ($urandom_range(3) == 0);
                    td    = t0 + 3 + int'($urandom_range(7));
                end
            end
        end else if (cyc == t0 + 1 || cyc == t0 + 2) begin
            if (flush_now) busy = 1'b0;
        end else if (walking) begin
            if (flush_now) disc = 1'b1;
            if (cyc == td && disc) busy = 1'b0;
        end else if (cyc == resp_cycle()) begin
            busy = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #3;
        check_and_update();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_grant(input string tag);
        for (int k = 0; k < 20 && !busy; k++) step();
        chk(tag, busy, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, {itlb_gnt_o, dtlb_gnt_o}, 2'b00);
        chk({tag, "_rspv"}, {itlb_rsp_valid_o, dtlb_rsp_valid_o}, 2'b00);
        chk({tag, "_strobes"}, {stlb_lu_valid_o, stlb_fill_o, ptw_req_o}, 3'b000);
        chk({tag, "_rsp_ppn"}, rsp_ppn_o, '0);
        chk({tag, "_rsp_err"}, rsp_err_o, 1'b0);
        chk({tag, "_lu_vpn"}, stlb_lu_vpn_o, '0);
        chk({tag, "_ptw_vpn"}, ptw_vpn_o, '0);
        chk({tag, "_fill_vpn"}, stlb_fill_vpn_o, '0);
        chk({tag, "_fill_ppn"}, stlb_fill_ppn_o, '0);
    endtask

    task automatic model_reset();
        busy = 1'b0; last_m = 1'b0; disc = 1'b0;
        ireq = 1'b0; dreq = 1'b0;
        gnt_log.delete();
    endtask

    task automatic apply_reset();
        ireq = 1'b0; dreq = 1'b0;
        itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
        ptw_done_i = 1'b0; flush_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        itlb_req_i = 1'b0; itlb_vpn_i = '0; dtlb_req_i = 1'b0; dtlb_vpn_i = '0;
        stlb_lu_hit_i = 1'b0; stlb_lu_ppn_i = '0;
        ptw_done_i = 1'b0; ptw_ppn_i = PPN_W'(44'hFFFF_0000_123); ptw_err_i = 1'b0;
        ivpn = '0; dvpn = '0; cyc = 0; t0 = 0; td = 0;
        t_hit = 1'b0; t_ppn = '0; t_err = 1'b0; t_vpn = '0; own_d = 1'b0;
        model_reset();
        apply_reset();

        // DTLB-only hit
        fp_en = 1'b1; fp_hit = 1'b1; fp_ppn = 44'hABCDE; fp_err = 1'b0; fp_lat = 0;
        dreq = 1'b1; dvpn = 27'h0_1234;
        run(6);

        // Both requesters held from reset: D, I, D, I
        apply_reset();
        hold_both = 1'b1; ivpn = 27'h111; dvpn = 27'h222;
        run(16);
        hold_both = 1'b0;
        chk("rr_count", 64'(gnt_log.size() >= 4), 64'd1);
        if (gnt_log.size() >= 4)
            chk("rr_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b1010);
        ireq = 1'b0; dreq = 1'b0;
        run(6);

        // ITLB miss with successful walk
        fp_hit = 1'b0; fp_ppn = 44'h12345; fp_err = 1'b0; fp_lat = 9;
        ireq = 1'b1; ivpn = 27'h7_FFFF;
        run(18);

        // DTLB miss with faulting walk
        fp_ppn = 44'h0BAD; fp_err = 1'b1; fp_lat = 3;
        dreq = 1'b1; dvpn = 27'h4_5678;
        run(12);

        // Flush during walk, ITLB waiting behind it
        fp_ppn = 44'h5555; fp_err = 1'b0; fp_lat = 6;
        dreq = 1'b1; dvpn = 27'h3_0303;
        wait_grant("flush_grant");
        flush_at = t0 + 5;
        ireq = 1'b1; ivpn = 27'h2_0202;
        run(24);
        flush_at = -1;

        // Reset mid-walk
        fp_lat = 20;
        dreq = 1'b1; dvpn = 27'h1_0101;
        wait_grant("rst_grant");
        run(6);
        chk("rst_in_walk", ptw_req_o, 1'b1);
        @(posedge clk);
        #2;
        ireq = 1'b0; dreq = 1'b0;
        itlb_req_i = 1'b0; dtlb_req_i = 1'b0; ptw_done_i = 1'b0; flush_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        fp_hit = 1'b1; fp_ppn = 44'h7777;
        ireq = 1'b1; dreq = 1'b1; ivpn = 27'h5; dvpn = 27'h6;
        run(2);
        chk("post_rst_first", 64'(gnt_log.size() > 0 && gnt_log[0]), 64'd1);
        run(10);

        // Randomized traffic
        fp_en = 1'b0;
        rnd   = 1'b1;
        run(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
